// File: rtl/uart_tx_cfg_if.sv
// Upstream word handshake for uart_tx_cfg: data plus valid/ready.
interface uart_tx_cfg_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start, DATA_WIDTH bits LSB-first, optional
// parity, 1 or 2 stop bits; format latched per frame at accept.
module uart_tx_cfg #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  uart_tx_cfg_if.slave bus,
  input  logic [1:0] parity_mode,
  input  logic       stop_bits,
  output logic       tx,
  output logic       busy
);

  localparam int CYCLES_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W          = $clog2(CYCLES_PER_BIT);
  localparam int IDX_W          = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [IDX_W-1:0]      idx, idx_n;
  logic [DATA_WIDTH-1:0] shift, shift_n;
  logic                  par_en, par_en_n;
  logic                  par_bit, par_bit_n;
  logic                  stop2, stop2_n;
  logic                  tx_n, busy_n;
  logic                  accept, bit_end;

  assign bus.tx_ready = (state == IDLE) && !reset;
  assign accept       = bus.tx_valid && bus.tx_ready;
  assign bit_end      = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      par_en  <= 1'b0;
      par_bit <= 1'b0;
      stop2   <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shift   <= shift_n;
      par_en  <= par_en_n;
      par_bit <= par_bit_n;
      stop2   <= stop2_n;
      tx      <= tx_n;
      busy    <= busy_n;
    end
  end

  // tx/busy are registered from the next-state view so the line changes
  // on the same edge as the state, keeping every bit exactly one period.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    shift_n   = shift;
    par_en_n  = par_en;
    par_bit_n = par_bit;
    stop2_n   = stop2;
    tx_n      = 1'b1;
    busy_n    = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          state_n   = START;
          cnt_n     = '0;
          idx_n     = '0;
          shift_n   = bus.tx_data;
          par_en_n  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
          par_bit_n = (parity_mode == 2'b10) ? ~^bus.tx_data : ^bus.tx_data;
          stop2_n   = stop_bits;
          tx_n      = 1'b0;
          busy_n    = 1'b1;
        end
      end

      START: begin
        busy_n = 1'b1;
        tx_n   = 1'b0;
        cnt_n  = cnt + 1'b1;
        if (bit_end) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = DATA;
          tx_n    = shift[0];
        end
      end

      DATA: begin
        busy_n = 1'b1;
        tx_n   = shift[0];
        cnt_n  = cnt + 1'b1;
        if (bit_end) begin
          cnt_n   = '0;
          shift_n = shift >> 1;
          if (idx == IDX_LAST) begin
            idx_n = '0;
            if (par_en) begin
              state_n = PARITY;
              tx_n    = par_bit;
            end else begin
              state_n = STOP;
              tx_n    = 1'b1;
            end
          end else begin
            idx_n = idx + 1'b1;
            tx_n  = shift[1];
          end
        end
      end

      PARITY: begin
        busy_n = 1'b1;
        tx_n   = par_bit;
        cnt_n  = cnt + 1'b1;
        if (bit_end) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = STOP;
          tx_n    = 1'b1;
        end
      end

      STOP: begin
        busy_n = 1'b1;
        tx_n   = 1'b1;
        cnt_n  = cnt + 1'b1;
        if (bit_end) begin
          cnt_n = '0;
          // idx counts completed stop periods
          if (stop2 && (idx == '0)) begin
            idx_n = idx + 1'b1;
          end else begin
            idx_n   = '0;
            state_n = IDLE;
            busy_n  = 1'b0;
          end
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        idx_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg at 10 clocks per bit, 8 data bits.
module tb_uart_tx_cfg;

  logic       clk;
  logic       reset;
  logic [1:0] parity_mode;
  logic       stop_bits;
  logic       tx;
  logic       busy;

  int nasserts = 0;
  int nfail    = 0;

  uart_tx_cfg_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_cfg #(
    .CLK_FREQ  (1_000_000),
    .BAUD_RATE (100_000),
    .DATA_WIDTH(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .parity_mode(parity_mode),
    .stop_bits  (stop_bits),
    .tx         (tx),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nasserts++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a word while idle; returns just after the accepting edge.
  task automatic send(input logic [7:0] data, input logic [1:0] pm, input logic sb);
    bus.tx_data  = data;
    parity_mode  = pm;
    stop_bits    = sb;
    bus.tx_valid = 1'b1;
    chk("pre_accept_ready", bus.tx_ready, 1'b1);
    tick();
    bus.tx_valid = 1'b0;
  endtask

  // bits[i] is the expected line level for bit period i (bit 0 = start).
  task automatic run_frame(input string tag, input int unsigned nbits, input logic [11:0] bits,
                           input int toggle_at, input int abort_at);
    int cyc;
    for (int unsigned b = 0; b < nbits; b++) begin
      for (int unsigned c = 0; c < 10; c++) begin
        cyc = int'(b * 10 + c);
        if (cyc == abort_at) return;
        if (cyc == toggle_at) begin
          parity_mode  = 2'b01;
          stop_bits    = 1'b1;
          bus.tx_data  = 8'hFF;
        end
        chk({tag, "/tx"}, tx, bits[b]);
        chk({tag, "/busy"}, busy, 1'b1);
        chk({tag, "/ready"}, bus.tx_ready, 1'b0);
        tick();
      end
    end
    chk({tag, "/end_tx"}, tx, 1'b1);
    chk({tag, "/end_busy"}, busy, 1'b0);
    chk({tag, "/end_ready"}, bus.tx_ready, 1'b1);
  endtask

  initial begin
    reset        = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    parity_mode  = 2'b00;
    stop_bits    = 1'b0;
    tick();
    tick();
    chk("reset_tx", tx, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_ready", bus.tx_ready, 1'b0);
    reset = 1'b0;
    #1;
    chk("post_reset_ready", bus.tx_ready, 1'b1);

    // 0xA5, no parity, one stop
    send(8'hA5, 2'b00, 1'b0);
    run_frame("a5_none", 10, {2'b00, 1'b1, 8'hA5, 1'b0}, -1, -1);

    // even parity of 0xA5 is 0, odd is 1
    send(8'hA5, 2'b01, 1'b0);
    run_frame("a5_even", 11, {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, -1, -1);
    send(8'hA5, 2'b10, 1'b0);
    run_frame("a5_odd", 11, {1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, -1, -1);

    // reserved mode behaves as no parity
    send(8'h0F, 2'b11, 1'b0);
    run_frame("0f_rsvd", 10, {2'b00, 1'b1, 8'h0F, 1'b0}, -1, -1);

    // 0x00 with two stop bits
    send(8'h00, 2'b00, 1'b1);
    run_frame("00_stop2", 11, {1'b0, 2'b11, 8'h00, 1'b0}, -1, -1);

    // back-to-back with valid held: one idle clock between frames
    bus.tx_data  = 8'h55;
    parity_mode  = 2'b00;
    stop_bits    = 1'b0;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_data = 8'hAA;
    run_frame("b2b_55", 10, {2'b00, 1'b1, 8'h55, 1'b0}, -1, -1);
    tick();
    bus.tx_valid = 1'b0;
    run_frame("b2b_aa", 10, {2'b00, 1'b1, 8'hAA, 1'b0}, -1, -1);

    // config and data changed mid-frame leave the current frame alone
    send(8'hA5, 2'b00, 1'b0);
    run_frame("cfg_hold", 10, {2'b00, 1'b1, 8'hA5, 1'b0}, 45, -1);
    chk("cfg_new_ready", bus.tx_ready, 1'b1);
    bus.tx_data  = 8'h3C;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    run_frame("cfg_new", 12, {2'b11, 1'b0, 8'h3C, 1'b0}, -1, -1);

    // reset mid-frame aborts at once
    send(8'hC3, 2'b00, 1'b0);
    run_frame("abort", 10, {2'b00, 1'b1, 8'hC3, 1'b0}, -1, 45);
    reset = 1'b1;
    tick();
    chk("abort_tx", tx, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ready", bus.tx_ready, 1'b0);
    reset = 1'b0;
    #1;
    chk("abort_ready_after", bus.tx_ready, 1'b1);
    tick();
    chk("abort_no_resume_tx", tx, 1'b1);
    chk("abort_no_resume_busy", busy, 1'b0);
    send(8'h5A, 2'b00, 1'b0);
    run_frame("after_abort", 10, {2'b00, 1'b1, 8'h5A, 1'b0}, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", nasserts, nfail);
    $finish;
  end

endmodule
